// File: rtl/mem_pkg.sv
// Shared memory-access encodings and helpers for the data-memory path.
// Imported by the load/store unit and the hazard logic.
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned OFF_W  = 2;

    typedef enum logic [1:0] {
        MASK_BYTE = 2'd0,
        MASK_HALF = 2'd1,
        MASK_WORD = 2'd2,
        MASK_RSVD = 2'd3
    } mask_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    typedef struct packed {
        logic [OFF_W-1:0] off;
        mask_e            mask;
        logic             sext;
    } ld_ctl_t;

    // Only byte/half stores are merged, so the low half of the data suffices
    typedef struct packed {
        logic [OFF_W-1:0]  off;
        mask_e             mask;
        logic [HALF_W-1:0] wdata;
    } st_ctl_t;

    function automatic mask_e norm_mask(input logic [1:0] m);
        return (m == 2'd3) ? MASK_WORD : mask_e'(m);
    endfunction

    function automatic logic is_misaligned(input mask_e m, input logic [OFF_W-1:0] off);
        logic mis;
        mis = 1'b0;
        case (m)
            MASK_HALF: mis = off[0];
            MASK_WORD: mis = |off;
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [OFF_W-1:0] align_off(input mask_e m, input logic [OFF_W-1:0] off);
        logic [OFF_W-1:0] a;
        a = off;
        case (m)
            MASK_HALF: a = {off[1], 1'b0};
            MASK_WORD: a = 2'b00;
            default:   a = off;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a RAM word and sign/zero extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  off,
    input  mask_e             mask,
    input  logic              sext,
    output logic [DATA_W-1:0] data_c
);

    logic [7:0]        byte_v;
    logic [HALF_W-1:0] half_v;

    always_comb begin : align_comb
        data_c = rdata;
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = rdata[{off[1], 4'b0000} +: 16];
        case (mask)
            MASK_BYTE: data_c = {{24{sext & byte_v[7]}}, byte_v};
            MASK_HALF: data_c = {{16{sext & half_v[15]}}, half_v};
            default:   data_c = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_rmw.sv
// Data-memory access stage: word stores/loads in one cycle, byte/half stores
// via a read-modify-write merge against a word-only synchronous RAM.
module dmem_rmw
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mem_memRead,
    input  logic              ex_mem_memWrite,
    input  logic [1:0]        ex_mem_maskMode,
    input  logic              ex_mem_sext,
    input  logic [31:0]       ex_mem_addr,
    input  logic [31:0]       ex_mem_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       ld_data,
    output logic              ld_valid,
    output logic              busy,
    output logic              misalign,
    output logic              protocol_err
);

    state_e            state;
    state_e            state_nxt;
    ld_ctl_t           ld_ctl;
    st_ctl_t           st_ctl;
    logic [ADDR_W-1:0] st_waddr;
    logic [31:0]       merged;
    logic [31:0]       align_data;

    mask_e             req_mask;
    logic [OFF_W-1:0]  req_off;
    logic [ADDR_W-1:0] req_waddr;
    logic              req_any;
    logic              in_idle;
    logic              ld_acc;
    logic              st_partial;

    // A simultaneous read+write is handled as a store
    assign req_mask   = norm_mask(ex_mem_maskMode);
    assign req_off    = align_off(req_mask, ex_mem_addr[1:0]);
    assign req_waddr  = ex_mem_addr[ADDR_W+1:2];
    assign req_any    = ex_mem_memRead | ex_mem_memWrite;
    assign in_idle    = (state == ST_IDLE);
    assign ld_acc     = in_idle & ex_mem_memRead & ~ex_mem_memWrite;
    assign st_partial = in_idle & ex_mem_memWrite & (req_mask != MASK_WORD);

    if (ADDR_W + 2 < 32) begin : g_unused_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^ex_mem_addr[31:ADDR_W+2];
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin : next_state_comb
        state_nxt = state;
        case (state)
            ST_IDLE:  if (st_partial) state_nxt = ST_MERGE;
            ST_MERGE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Access control captured at acceptance; used by the following cycle
    always_ff @(posedge clk or negedge rst_n) begin : ctl_reg
        if (!rst_n) begin
            ld_valid <= 1'b0;
            ld_ctl   <= '0;
            st_ctl   <= '0;
            st_waddr <= '0;
        end else begin
            ld_valid <= ld_acc;
            if (ld_acc) begin
                ld_ctl <= '{off: req_off, mask: req_mask, sext: ex_mem_sext};
            end
            if (st_partial) begin
                st_ctl   <= '{off: req_off, mask: req_mask, wdata: ex_mem_wdata[HALF_W-1:0]};
                st_waddr <= req_waddr;
            end
        end
    end

    always_comb begin : merge_comb
        merged = ram_rdata;
        case (st_ctl.mask)
            MASK_BYTE: merged[{st_ctl.off, 3'b000} +: 8]     = st_ctl.wdata[7:0];
            MASK_HALF: merged[{st_ctl.off[1], 4'b0000} +: 16] = st_ctl.wdata;
            default:   merged = ram_rdata;
        endcase
    end

    // RAM port and status pulses; all forced quiet while reset is held
    always_comb begin : out_comb
        ram_addr     = req_waddr;
        ram_we       = 1'b0;
        ram_wdata    = ex_mem_wdata;
        busy         = 1'b0;
        misalign     = 1'b0;
        protocol_err = 1'b0;
        case (state)
            ST_IDLE: begin
                misalign     = req_any & is_misaligned(req_mask, ex_mem_addr[1:0]);
                protocol_err = ex_mem_memRead & ex_mem_memWrite;
                ram_we       = ex_mem_memWrite & (req_mask == MASK_WORD);
            end
            ST_MERGE: begin
                ram_addr     = st_waddr;
                ram_we       = 1'b1;
                ram_wdata    = merged;
                busy         = 1'b1;
                protocol_err = req_any;
            end
            default: ;
        endcase
        if (!rst_n) begin
            ram_we       = 1'b0;
            busy         = 1'b0;
            misalign     = 1'b0;
            protocol_err = 1'b0;
        end
    end

    load_align u_load_align (
        .rdata  (ram_rdata),
        .off    (ld_ctl.off),
        .mask   (ld_ctl.mask),
        .sext   (ld_ctl.sext),
        .data_c (align_data)
    );

    assign ld_data = ld_valid ? align_data : 32'h0;

endmodule

// File: tb/tb_dmem_rmw.sv
// Bench for dmem_rmw: directed vector table, hand-written corner sequences,
// then random traffic checked against a byte-arithmetic memory model.
module tb_dmem_rmw;

    localparam int unsigned ADDR_W = 12;
    localparam int RAND_N = 2000;
    localparam int TOTAL  = 16 + RAND_N + 1 + 16 + 1;

    logic              clk;
    logic              rst_n;
    logic              ex_mem_memRead;
    logic              ex_mem_memWrite;
    logic [1:0]        ex_mem_maskMode;
    logic              ex_mem_sext;
    logic [31:0]       ex_mem_addr;
    logic [31:0]       ex_mem_wdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       ld_data;
    logic              ld_valid;
    logic              busy;
    logic              misalign;
    logic              protocol_err;

    int n_asserts = 0;
    int n_fail    = 0;

    dmem_rmw #(.ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_mem_memRead  (ex_mem_memRead),
        .ex_mem_memWrite (ex_mem_memWrite),
        .ex_mem_maskMode (ex_mem_maskMode),
        .ex_mem_sext     (ex_mem_sext),
        .ex_mem_addr     (ex_mem_addr),
        .ex_mem_wdata    (ex_mem_wdata),
        .ram_addr        (ram_addr),
        .ram_we          (ram_we),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .ld_data         (ld_data),
        .ld_valid        (ld_valid),
        .busy            (busy),
        .misalign        (misalign),
        .protocol_err    (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous word-write RAM, read-first
    logic [31:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] mask,
                         input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
        ex_mem_memRead  = rd;
        ex_mem_memWrite = wr;
        ex_mem_maskMode = mask;
        ex_mem_sext     = sext;
        ex_mem_addr     = addr;
        ex_mem_wdata    = wdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic        is_store;
        logic [31:0] init;
        logic [1:0]  off;
        logic [1:0]  mask;
        logic        sext;
        logic [31:0] din;
        logic        exp_mis;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    // Model state for the random phase
    logic [31:0] ref_mem [16];
    logic        pend_ld;
    logic [31:0] pend_data;
    logic        mpend;
    logic [11:0] m_addr;
    logic [31:0] m_word;

    initial begin : main
        logic        r_rd, r_wr, r_sext, wordop;
        logic [1:0]  r_mask, r_off;
        logic [3:0]  r_word;
        logic [31:0] r_data, r_addr, bm, v;
        logic        e_we, e_busy, e_perr, e_mis, e_ldv;
        logic [31:0] e_wd, e_ldd;
        logic [11:0] e_addr;
        int          sel, eff, base, nbits;

        vecs[0]  = '{1'b1, 32'h11223344, 2'd1, 2'd0, 1'b0, 32'h000000AA, 1'b0, 32'h1122AA44};
        vecs[1]  = '{1'b0, 32'h8000F0FF, 2'd2, 2'd1, 1'b1, 32'h0,        1'b0, 32'hFFFF8000};
        vecs[2]  = '{1'b0, 32'h8000F0FF, 2'd2, 2'd1, 1'b0, 32'h0,        1'b0, 32'h00008000};
        vecs[3]  = '{1'b0, 32'h8000F0FF, 2'd0, 2'd0, 1'b1, 32'h0,        1'b0, 32'hFFFFFFFF};
        vecs[4]  = '{1'b1, 32'hCAFEBABE, 2'd1, 2'd1, 1'b0, 32'h00001234, 1'b1, 32'hCAFE1234};
        vecs[5]  = '{1'b0, 32'h8000F0FF, 2'd3, 2'd0, 1'b0, 32'h0,        1'b0, 32'h00000080};
        vecs[6]  = '{1'b0, 32'h8000F0FF, 2'd1, 2'd0, 1'b1, 32'h0,        1'b0, 32'hFFFFFFF0};
        vecs[7]  = '{1'b0, 32'h8000F0FF, 2'd2, 2'd2, 1'b1, 32'h0,        1'b1, 32'h8000F0FF};
        vecs[8]  = '{1'b0, 32'h12345678, 2'd0, 2'd3, 1'b1, 32'h0,        1'b0, 32'h12345678};
        vecs[9]  = '{1'b1, 32'h11223344, 2'd3, 2'd0, 1'b0, 32'h12345655, 1'b0, 32'h55223344};
        vecs[10] = '{1'b1, 32'h11223344, 2'd2, 2'd1, 1'b0, 32'hFFFFBEEF, 1'b0, 32'hBEEF3344};
        vecs[11] = '{1'b1, 32'h11223344, 2'd1, 2'd3, 1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        vecs[12] = '{1'b0, 32'h8000F0FF, 2'd3, 2'd1, 1'b1, 32'h0,        1'b1, 32'hFFFF8000};
        vecs[13] = '{1'b0, 32'h8000F0FF, 2'd0, 2'd1, 1'b1, 32'h0,        1'b0, 32'hFFFFF0FF};

        // Reset: outputs quiet even with a conflicting misaligned request applied
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h13, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_ram_we", ram_we, 1'b0);
        chk1("rst_ld_valid", ld_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_misalign", misalign, 1'b0);
        chk1("rst_protocol_err", protocol_err, 1'b0);
        chk("rst_ld_data", ld_data, 32'h0);
        rst_n = 1'b1;
        idle();
        @(negedge clk);

        // Vector table: each entry operates on word 0x10
        for (int i = 0; i < 14; i++) begin
            wordop = (vecs[i].mask >= 2'd2);
            drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, vecs[i].init);
            #1 chk1("tbl_init_we", ram_we, 1'b1);
            @(negedge clk);
            drive(~vecs[i].is_store, vecs[i].is_store, vecs[i].mask, vecs[i].sext,
                  32'h40 | {30'd0, vecs[i].off}, vecs[i].din);
            #1;
            chk1("tbl_misalign", misalign, vecs[i].exp_mis);
            if (vecs[i].is_store && wordop) begin
                chk1("tbl_sw_we", ram_we, 1'b1);
                chk("tbl_sw_wdata", ram_wdata, vecs[i].exp);
            end else begin
                chk1("tbl_acc_we", ram_we, 1'b0);
            end
            @(negedge clk);
            idle();
            #1;
            if (vecs[i].is_store && !wordop) begin
                chk1("tbl_merge_busy", busy, 1'b1);
                chk1("tbl_merge_we", ram_we, 1'b1);
                chk("tbl_merge_wdata", ram_wdata, vecs[i].exp);
                chk("tbl_merge_addr", 32'(ram_addr), 32'h10);
            end else begin
                chk1("tbl_next_we", ram_we, 1'b0);
                chk1("tbl_ld_valid", ld_valid, ~vecs[i].is_store);
                if (!vecs[i].is_store) chk("tbl_ld_data", ld_data, vecs[i].exp);
            end
            @(negedge clk);
            drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
            #1;
            chk1("tbl_after_busy", busy, 1'b0);
            chk1("tbl_after_ldv", ld_valid, 1'b0);
            @(negedge clk);
            idle();
            #1 chk("tbl_readback", ld_data, vecs[i].is_store ? vecs[i].exp : vecs[i].init);
            @(negedge clk);
        end

        // Store then immediate load of the same word
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h80, 32'hDEADBEEF);
        #1;
        chk1("swlw_we", ram_we, 1'b1);
        chk("swlw_wdata", ram_wdata, 32'hDEADBEEF);
        chk("swlw_addr", 32'(ram_addr), 32'h20);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
        #1;
        chk1("swlw_c1_ldv", ld_valid, 1'b0);
        chk1("swlw_c1_we", ram_we, 1'b0);
        @(negedge clk);
        idle();
        #1;
        chk1("swlw_c2_ldv", ld_valid, 1'b1);
        chk("swlw_c2_data", ld_data, 32'hDEADBEEF);
        @(negedge clk);
        #1 chk1("swlw_c3_ldv", ld_valid, 1'b0);
        @(negedge clk);

        // Read and write together: a word store plus protocol_err
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'hC0, 32'h0BADF00D);
        #1;
        chk1("both_perr", protocol_err, 1'b1);
        chk1("both_we", ram_we, 1'b1);
        chk("both_wdata", ram_wdata, 32'h0BADF00D);
        @(negedge clk);
        idle();
        #1;
        chk1("both_ldv", ld_valid, 1'b0);
        chk1("both_perr_clear", protocol_err, 1'b0);
        @(negedge clk);

        // Load presented during a merge is ignored
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h40, 32'h00000077);
        #1 chk1("mrgld_accept_we", ram_we, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b1, 32'hC1, 32'h0);
        #1;
        chk1("mrgld_perr", protocol_err, 1'b1);
        chk1("mrgld_we", ram_we, 1'b1);
        chk1("mrgld_busy", busy, 1'b1);
        chk1("mrgld_mis", misalign, 1'b0);
        chk("mrgld_wdata", ram_wdata, 32'h11223377);
        chk("mrgld_addr", 32'(ram_addr), 32'h10);
        @(negedge clk);
        idle();
        #1;
        chk1("mrgld_ldv", ld_valid, 1'b0);
        chk1("mrgld_busy_end", busy, 1'b0);
        chk1("mrgld_perr_end", protocol_err, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        idle();
        #1 chk("mrgld_readback", ld_data, 32'h11223377);
        @(negedge clk);

        // Reset in the merge cycle aborts the write
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h42, 32'h00000099);
        @(negedge clk);
        idle();
        #1 chk1("rstm_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rstm_we", ram_we, 1'b0);
        chk1("rstm_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("rstm_rel_busy", busy, 1'b0);
        chk1("rstm_rel_we", ram_we, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        idle();
        #1;
        chk1("rstm_ldv", ld_valid, 1'b1);
        chk("rstm_unchanged", ld_data, 32'h11223344);
        @(negedge clk);

        // Random traffic on words 0..15 against the reference model
        pend_ld = 1'b0;
        mpend   = 1'b0;
        pend_data = 32'h0;
        m_addr  = 12'h0;
        m_word  = 32'h0;
        for (int c = 0; c < TOTAL; c++) begin
            r_rd = 1'b0; r_wr = 1'b0; r_mask = 2'd2; r_off = 2'd0;
            r_sext = 1'b0; r_word = 4'd0; r_data = $urandom;
            if (c < 16) begin
                r_wr = 1'b1;
                r_word = 4'(c);
            end else if (c < 16 + RAND_N) begin
                sel    = int'($urandom_range(0, 9));
                r_rd   = (sel < 4) || (sel == 9);
                r_wr   = (sel >= 4 && sel < 8) || (sel == 9);
                r_mask = 2'($urandom_range(0, 3));
                r_off  = 2'($urandom_range(0, 3));
                r_word = 4'($urandom_range(0, 15));
                r_sext = 1'($urandom_range(0, 1));
            end else if (c > 16 + RAND_N && c <= 16 + RAND_N + 16) begin
                r_rd = 1'b1;
                r_word = 4'(c - (17 + RAND_N));
            end
            r_addr = ($urandom & 32'hFFFF_C000) | {24'd0, 2'd0, r_word, r_off};
            drive(r_rd, r_wr, r_mask, r_sext, r_addr, r_data);

            e_ldv = pend_ld;
            e_ldd = pend_ld ? pend_data : 32'h0;
            e_we  = 1'b0;
            e_wd  = 32'h0;
            pend_ld = 1'b0;
            if (mpend) begin
                e_we   = 1'b1;
                e_wd   = m_word;
                e_addr = m_addr;
                e_busy = 1'b1;
                e_perr = r_rd | r_wr;
                e_mis  = 1'b0;
                mpend  = 1'b0;
            end else begin
                e_busy = 1'b0;
                e_addr = {8'd0, r_word};
                e_perr = r_rd & r_wr;
                eff    = (r_mask == 2'd3) ? 2 : int'(r_mask);
                e_mis  = (r_rd | r_wr) && ((eff == 1 && r_off[0]) || (eff == 2 && r_off != 2'd0));
                base   = (eff == 2) ? 0 : (eff == 1) ? int'(r_off & 2'd2) : int'(r_off);
                nbits  = (eff == 0) ? 8 : (eff == 1) ? 16 : 32;
                bm     = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
                if (r_wr) begin
                    if (eff == 2) begin
                        e_we = 1'b1;
                        e_wd = r_data;
                        ref_mem[r_word] = r_data;
                    end else begin
                        v = (ref_mem[r_word] & ~(bm << (8 * base))) | ((r_data & bm) << (8 * base));
                        ref_mem[r_word] = v;
                        mpend  = 1'b1;
                        m_addr = {8'd0, r_word};
                        m_word = v;
                    end
                end else if (r_rd) begin
                    v = (ref_mem[r_word] >> (8 * base)) & bm;
                    if (r_sext && v[nbits-1]) v = v | ~bm;
                    pend_ld   = 1'b1;
                    pend_data = v;
                end
            end

            #1;
            chk1("rnd_we", ram_we, e_we);
            chk1("rnd_busy", busy, e_busy);
            chk1("rnd_perr", protocol_err, e_perr);
            chk1("rnd_mis", misalign, e_mis);
            chk1("rnd_ldv", ld_valid, e_ldv);
            chk("rnd_ldd", ld_data, e_ldd);
            chk("rnd_addr", 32'(ram_addr), 32'(e_addr));
            if (e_we) chk("rnd_wdata", ram_wdata, e_wd);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
